usb_token_rx: RTL

- Receive-side USB token packet decoder. Sits between the bit-unstuffing stage and the device protocol engine.
- Consumes the de-stuffed serial bitstream (LSB first), assembles the PID and the 11-bit token body, and checks the PID complement.
- Checks CRC5 over the body through an internal crc5 instance (init all ones, polynomial 1+x^2+x^5).
- Emits one result per packet: either a decoded token pulse or an error pulse with a cause code.

---
 rtl/usb_pkg.sv | 48 ++++
 rtl/usb_token_rx_crc5.sv | 27 ++
 rtl/usb_token_rx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// Shared definitions for the USB token receive path: PIDs, error causes, FSM states.
package usb_pkg;

   localparam int unsigned PID_W  = 8;
   localparam int unsigned BODY_W = 11;
   localparam int unsigned CRC_W  = 5;
   localparam int unsigned CNT_W  = 4;

   // Token PIDs (low nibble of the PID byte)
   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_SETUP = 4'b1101;
   localparam logic [3:0] PID_SOF   = 4'b0101;

   // Error cause codes reported with tok_err
   localparam logic [1:0] ERR_PID  = 2'd0;
   localparam logic [1:0] ERR_CRC  = 2'd1;
   localparam logic [1:0] ERR_LEN  = 2'd2;
   localparam logic [1:0] ERR_LINE = 2'd3;

   // CRC5 generator 1 + x^2 + x^5 (x^5 term implicit) and its seed
   localparam logic [CRC_W-1:0] CRC5_POLY = 5'b00101;
   localparam logic [CRC_W-1:0] CRC5_INIT = 5'b11111;

   // Receiver state encoding
   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_PID      = 3'd1;
   localparam logic [2:0] S_BODY     = 3'd2;
   localparam logic [2:0] S_EOPW     = 3'd3;
   localparam logic [2:0] S_DROP     = 3'd4;
   localparam logic [2:0] S_ERR_WAIT = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE     = S_IDLE,
      ST_PID      = S_PID,
      ST_BODY     = S_BODY,
      ST_EOPW     = S_EOPW,
      ST_DROP     = S_DROP,
      ST_ERR_WAIT = S_ERR_WAIT
   } state_t;

   // True when the PID nibble names a token this receiver should decode
   function automatic logic is_token_pid(input logic [3:0] pid, input logic sof_en);
      return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SETUP) ||
             ((pid == PID_SOF) && sof_en);
   endfunction

endpackage

// File: rtl/usb_token_rx_crc5.sv
// Serial USB CRC5 checker: one bit per enabled cycle, synchronous clear to all ones.
module crc5
   import usb_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             data_in,
   input  logic             crc_en,
   output logic [CRC_W-1:0] crc_out
);

   logic [CRC_W-1:0] crc_q;
   logic             fb;

   assign fb      = crc_q[CRC_W-1] ^ data_in;
   assign crc_out = crc_q;

   // Shift the LFSR on each enabled bit; clear reloads the seed
   always_ff @(posedge clk) begin
      if (rst) begin
         crc_q <= CRC5_INIT;
      end else if (crc_en) begin
         crc_q <= {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC5_POLY : CRC_W'(0));
      end
   end

endmodule

// File: rtl/usb_token_rx.sv
// USB token packet decoder: PID check, 11-bit body capture, CRC5 check, one result per packet.
module usb_token_rx
   import usb_pkg::*;
#(
   parameter bit         SOF_EN        = 1'b1,
   parameter logic [4:0] CRC5_RESIDUAL = 5'b01100
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_sop,
   input  logic        rx_bit,
   input  logic        rx_bit_valid,
   input  logic        rx_eop,
   input  logic        rx_err,
   output logic        tok_valid,
   output logic [3:0]  tok_pid,
   output logic [6:0]  tok_addr,
   output logic [3:0]  tok_endp,
   output logic [10:0] tok_frame,
   output logic        tok_err,
   output logic [1:0]  tok_err_code
);

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [PID_W-1:0]    pid_q;
   logic [BODY_W-1:0]   body_q;
   logic [1:0]          err_code_q;

   logic                tok_valid_q;
   logic [3:0]          tok_pid_q;
   logic [6:0]          tok_addr_q;
   logic [3:0]          tok_endp_q;
   logic [10:0]         tok_frame_q;
   logic                tok_err_q;
   logic [1:0]          tok_err_code_q;

   logic [PID_W-1:0]    pid_d;
   logic [BODY_W-1:0]   body_d;
   logic [CNT_W-1:0]    cnt_d;
   logic                pid_ok;
   logic                crc_clr;
   logic                crc_en;
   logic [CRC_W-1:0]    crc_out;

   // Bits arrive LSB first, so each new bit enters at the top and shifts down
   assign pid_d   = {rx_bit, pid_q[PID_W-1:1]};
   assign body_d  = {rx_bit, body_q[BODY_W-1:1]};
   assign pid_ok  = (pid_d[7:4] == ~pid_d[3:0]);
   assign cnt_d   = (cnt_q == CNT_W'(15)) ? cnt_q : cnt_q + CNT_W'(1);

   // CRC restarts on every start of packet and sees all 16 body+CRC bits
   assign crc_clr = rx_sop;
   assign crc_en  = (state_q == ST_BODY) && rx_bit_valid;

   crc5 u_crc5 (
      .clk     (clk),
      .rst     (crc_clr),
      .data_in (rx_bit),
      .crc_en  (crc_en),
      .crc_out (crc_out)
   );

   // Packet FSM with registered result pulses and held token fields
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         pid_q          <= '0;
         body_q         <= '0;
         err_code_q     <= '0;
         tok_valid_q    <= 1'b0;
         tok_pid_q      <= '0;
         tok_addr_q     <= '0;
         tok_endp_q     <= '0;
         tok_frame_q    <= '0;
         tok_err_q      <= 1'b0;
         tok_err_code_q <= '0;
      end else begin
         tok_valid_q <= 1'b0;
         tok_err_q   <= 1'b0;

         if (rx_sop) begin
            state_q    <= ST_PID;
            cnt_q      <= '0;
            pid_q      <= '0;
            body_q     <= '0;
            err_code_q <= '0;
         end else if ((state_q != ST_IDLE) && rx_err) begin
            if (rx_eop) begin
               tok_err_q      <= 1'b1;
               tok_err_code_q <= ERR_LINE;
               state_q        <= ST_IDLE;
            end else begin
               err_code_q <= ERR_LINE;
               state_q    <= ST_ERR_WAIT;
            end
         end else begin
            case (state_q)
               ST_IDLE: begin
                  cnt_q <= '0;
               end

               ST_PID: begin
                  if (rx_eop) begin
                     tok_err_q      <= 1'b1;
                     tok_err_code_q <= ERR_LEN;
                     state_q        <= ST_IDLE;
                  end else if (rx_bit_valid) begin
                     pid_q <= pid_d;
                     if (cnt_q == CNT_W'(7)) begin
                        cnt_q <= '0;
                        if (!pid_ok) begin
                           err_code_q <= ERR_PID;
                           state_q    <= ST_ERR_WAIT;
                        end else if (is_token_pid(pid_d[3:0], 1'(SOF_EN))) begin
                           state_q <= ST_BODY;
                        end else begin
                           state_q <= ST_DROP;
                        end
                     end else begin
                        cnt_q <= cnt_d;
                     end
                  end
               end

               ST_BODY: begin
                  if (rx_eop) begin
                     tok_err_q      <= 1'b1;
                     tok_err_code_q <= ERR_LEN;
                     state_q        <= ST_IDLE;
                  end else if (rx_bit_valid) begin
                     if (cnt_q < CNT_W'(BODY_W)) begin
                        body_q <= body_d;
                     end
                     if (cnt_q == CNT_W'(15)) begin
                        state_q <= ST_EOPW;
                     end
                     cnt_q <= cnt_d;
                  end
               end

               ST_EOPW: begin
                  if (rx_bit_valid) begin
                     err_code_q <= ERR_LEN;
                     state_q    <= ST_ERR_WAIT;
                  end else if (rx_eop) begin
                     if (crc_out == CRC5_RESIDUAL) begin
                        tok_valid_q <= 1'b1;
                        tok_pid_q   <= pid_q[3:0];
                        tok_addr_q  <= body_q[6:0];
                        tok_endp_q  <= body_q[10:7];
                        tok_frame_q <= body_q;
                     end else begin
                        tok_err_q      <= 1'b1;
                        tok_err_code_q <= ERR_CRC;
                     end
                     state_q <= ST_IDLE;
                  end
               end

               ST_DROP: begin
                  if (rx_eop) begin
                     state_q <= ST_IDLE;
                  end
               end

               ST_ERR_WAIT: begin
                  if (rx_eop) begin
                     tok_err_q      <= 1'b1;
                     tok_err_code_q <= err_code_q;
                     state_q        <= ST_IDLE;
                  end
               end

               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign tok_valid    = tok_valid_q;
   assign tok_pid      = tok_pid_q;
   assign tok_addr     = tok_addr_q;
   assign tok_endp     = tok_endp_q;
   assign tok_frame    = tok_frame_q;
   assign tok_err      = tok_err_q;
   assign tok_err_code = tok_err_code_q;

endmodule
